// File: rtl/cv32e40p_ft_health_monitor_if.sv
// Health-monitor port bundle: TMR disagreement samples in, exclusion requests and status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; set_broken_o/is_broken_i form a level request/confirm handshake.
interface cv32e40p_ft_health_monitor_if;
  logic        valid_i;
  logic [2:0]  mismatch_i;
  logic [2:0]  is_broken_i;
  logic        clear_i;
  logic [2:0]  set_broken_o;
  logic        err_detected_o;
  logic        err_corrected_o;
  logic        fatal_o;
  logic [15:0] err_count_o;

  // Fault-tolerance / TMR side: drives samples, observes status
  modport master (
    output valid_i, mismatch_i, is_broken_i, clear_i,
    input  set_broken_o, err_detected_o, err_corrected_o, fatal_o, err_count_o
  );

  // Health monitor side
  modport slave (
    input  valid_i, mismatch_i, is_broken_i, clear_i,
    output set_broken_o, err_detected_o, err_corrected_o, fatal_o, err_count_o
  );
endinterface

// File: rtl/cv32e40p_ft_health_monitor.sv
// Per-replica leaky error scoring for the TMR instruction path; requests exclusion of one broken replica.
// Latency: all outputs registered, one cycle after the sampled cycle.
// Backpressure: none; every cycle is sampled, set_broken_o is held until is_broken_i confirms it.
// Optional feature: define FT_HEALTH_DECAY_EN to build the leaky score decay (clean counters).
module cv32e40p_ft_health_monitor #(
  parameter int unsigned ERR_THRESHOLD = 8,
  parameter int unsigned DECAY_PERIOD  = 16
) (
  input logic                         clk,
  input logic                         rst_n,
  cv32e40p_ft_health_monitor_if.slave bus
);

  localparam int unsigned SW = $clog2(ERR_THRESHOLD + 1);
  localparam logic [SW-1:0] THR = SW'(ERR_THRESHOLD);

  typedef enum logic [1:0] {
    HEALTHY    = 2'd0,
    SUSPECT    = 2'd1,
    BROKEN_REQ = 2'd2,
    BROKEN     = 2'd3
  } rep_state_t;

  rep_state_t    state [3];
  logic [SW-1:0] score [3];

`ifdef FT_HEALTH_DECAY_EN
  localparam int unsigned CW = $clog2(DECAY_PERIOD);
  localparam logic [CW-1:0] CLEAN_LAST = CW'(DECAY_PERIOD - 1);
  logic [CW-1:0] clean [3];
`else
  // The decay period only matters when the clean counters are built in
  logic unused_decay_cfg;
  assign unused_decay_cfg = (DECAY_PERIOD >= 2);
`endif

  logic [2:0]    set_broken;
  logic          err_detected;
  logic          err_corrected;
  logic          fatal;
  logic [15:0]   err_count;

  logic [2:0]    masked;
  logic [2:0]    unmasked;
  logic [2:0]    reach;
  logic [2:0]    grant;
  logic [1:0]    um_cnt;
  logic [1:0]    reach_cnt;
  logic          any_excl;
  logic          multi;
  logic          conflict;
  logic [SW-1:0] score_inc [3];

  // Masking, multi-bit detection and single-broken arbitration for this sample
  always_comb begin
    masked   = '0;
    reach    = '0;
    grant    = '0;
    for (int i = 0; i < 3; i++) begin
      masked[i]    = (state[i] == BROKEN_REQ) || (state[i] == BROKEN);
      score_inc[i] = (score[i] == THR) ? score[i] : score[i] + SW'(1);
    end
    unmasked  = {3{bus.valid_i}} & bus.mismatch_i & ~masked;
    um_cnt    = {1'b0, unmasked[0]} + {1'b0, unmasked[1]} + {1'b0, unmasked[2]};
    any_excl  = |masked;
    // With a replica already excluded, any remaining disagreement means no majority
    multi     = (um_cnt >= 2'd2) || ((|unmasked) && any_excl);
    for (int i = 0; i < 3; i++) begin
      reach[i] = unmasked[i] && (score_inc[i] == THR);
    end
    reach_cnt = {1'b0, reach[0]} + {1'b0, reach[1]} + {1'b0, reach[2]};
    // Only a lone threshold crossing with nobody else excluded may raise a request
    if (!any_excl && (reach_cnt == 2'd1)) begin
      grant = reach;
    end
    conflict  = (|reach) && (any_excl || (reach_cnt >= 2'd2));
  end

  // Replica FSMs, scores, decay counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= HEALTHY;
        score[i] <= '0;
`ifdef FT_HEALTH_DECAY_EN
        clean[i] <= '0;
`endif
      end
      set_broken    <= '0;
      err_detected  <= 1'b0;
      err_corrected <= 1'b0;
      fatal         <= 1'b0;
      err_count     <= '0;
    end else if (bus.clear_i) begin
      // Clear wins over every same-cycle event; the event counter is history and survives
      for (int i = 0; i < 3; i++) begin
        state[i] <= HEALTHY;
        score[i] <= '0;
`ifdef FT_HEALTH_DECAY_EN
        clean[i] <= '0;
`endif
      end
      set_broken    <= '0;
      err_detected  <= 1'b0;
      err_corrected <= 1'b0;
      fatal         <= 1'b0;
    end else begin
      err_detected  <= |unmasked;
      err_corrected <= (|unmasked) && !multi;
      if ((|unmasked) && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
      if (multi || conflict) begin
        fatal <= 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        case (state[i])
          HEALTHY, SUSPECT: begin
            if (unmasked[i]) begin
              score[i] <= score_inc[i];
`ifdef FT_HEALTH_DECAY_EN
              clean[i] <= '0;
`endif
              if (grant[i]) begin
                state[i]      <= BROKEN_REQ;
                set_broken[i] <= 1'b1;
              end else begin
                state[i] <= SUSPECT;
              end
            end
`ifdef FT_HEALTH_DECAY_EN
            else if (bus.valid_i && (state[i] == SUSPECT)) begin
              if (clean[i] == CLEAN_LAST) begin
                clean[i] <= '0;
                score[i] <= (score[i] == '0) ? '0 : score[i] - SW'(1);
                if (score[i] <= SW'(1)) begin
                  state[i] <= HEALTHY;
                end
              end else begin
                clean[i] <= clean[i] + CW'(1);
              end
            end
`endif
          end
          // The TMR confirmation is a handshake, not a data sample, so it is taken regardless of valid
          BROKEN_REQ: begin
            if (bus.is_broken_i[i]) begin
              state[i]      <= BROKEN;
              set_broken[i] <= 1'b0;
            end
          end
          BROKEN: begin
            state[i] <= BROKEN;
          end
        endcase
      end
    end
  end

  assign bus.set_broken_o    = set_broken;
  assign bus.err_detected_o  = err_detected;
  assign bus.err_corrected_o = err_corrected;
  assign bus.fatal_o         = fatal;
  assign bus.err_count_o     = err_count;

endmodule

// File: tb/tb_cv32e40p_ft_health_monitor.sv
// Directed bench for the TMR health monitor (ERR_THRESHOLD=4, DECAY_PERIOD=8).
// Expectations follow FT_HEALTH_DECAY_EN when it is defined for the whole build.
module tb_cv32e40p_ft_health_monitor;
`ifdef FT_HEALTH_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_ft_health_monitor_if bus ();

  cv32e40p_ft_health_monitor #(
    .ERR_THRESHOLD(4),
    .DECAY_PERIOD (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_cnt = 0;
  logic [2:0] ib = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One sampled cycle; outputs are looked at 1 time unit after the edge
  task automatic cyc(input logic v, input logic [2:0] mm, input logic clr);
    bus.valid_i     = v;
    bus.mismatch_i  = mm;
    bus.clear_i     = clr;
    bus.is_broken_i = ib;
    @(posedge clk);
    #1;
    bus.valid_i    = 1'b0;
    bus.mismatch_i = 3'b000;
    bus.clear_i    = 1'b0;
  endtask

  initial begin
    bus.valid_i     = 1'b0;
    bus.mismatch_i  = 3'b000;
    bus.is_broken_i = 3'b000;
    bus.clear_i     = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state after 10 idle cycles
    repeat (10) cyc(1'b0, 3'b000, 1'b0);
    chk("rst_set_broken", 32'(bus.set_broken_o), 32'd0);
    chk("rst_detected", 32'(bus.err_detected_o), 32'd0);
    chk("rst_corrected", 32'(bus.err_corrected_o), 32'd0);
    chk("rst_fatal", 32'(bus.fatal_o), 32'd0);
    chk("rst_count", 32'(bus.err_count_o), 32'd0);

    // Replica 0 reaches threshold after 4 single-bit mismatches
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 3'b001, 1'b0);
      exp_cnt++;
      chk("a_detected", 32'(bus.err_detected_o), 32'd1);
      chk("a_corrected", 32'(bus.err_corrected_o), 32'd1);
      chk("a_set_broken", 32'(bus.set_broken_o), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("a_count4", 32'(bus.err_count_o), 32'd4);
    cyc(1'b0, 3'b111, 1'b0);
    chk("a_invalid_det", 32'(bus.err_detected_o), 32'd0);
    chk("a_invalid_cnt", 32'(bus.err_count_o), 32'd4);
    cyc(1'b0, 3'b000, 1'b0);
    chk("a_req_held", 32'(bus.set_broken_o), 32'd1);
    ib = 3'b001;
    cyc(1'b0, 3'b000, 1'b0);
    chk("a_req_drop", 32'(bus.set_broken_o), 32'd0);
    repeat (2) begin
      cyc(1'b1, 3'b001, 1'b0);
      chk("a_masked_det", 32'(bus.err_detected_o), 32'd0);
      chk("a_masked_corr", 32'(bus.err_corrected_o), 32'd0);
    end
    chk("a_masked_cnt", 32'(bus.err_count_o), 32'd4);
    chk("a_fatal", 32'(bus.fatal_o), 32'd0);

    // Clear keeps the event count; 3 hits then 8 clean cycles leaves score 2
    ib = 3'b000;
    cyc(1'b0, 3'b000, 1'b1);
    chk("b_clr_sb", 32'(bus.set_broken_o), 32'd0);
    chk("b_clr_cnt", 32'(bus.err_count_o), 32'd4);
    repeat (3) begin cyc(1'b1, 3'b010, 1'b0); exp_cnt++; end
    repeat (8) cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    exp_cnt++;
    chk("b_after_decay1", 32'(bus.set_broken_o), DECAY ? 32'd0 : 32'd2);
    cyc(1'b1, 3'b010, 1'b0);
    exp_cnt += DECAY ? 1 : 0;
    chk("b_after_decay2", 32'(bus.set_broken_o), 32'd2);
    chk("b_count", 32'(bus.err_count_o), 32'(exp_cnt));

    // 7 clean cycles are one short of a decrement
    cyc(1'b0, 3'b000, 1'b1);
    repeat (3) begin cyc(1'b1, 3'b010, 1'b0); exp_cnt++; end
    repeat (7) cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    exp_cnt++;
    chk("b_no_early_decay", 32'(bus.set_broken_o), 32'd2);

    // 24 clean cycles bring score 3 back to HEALTHY
    cyc(1'b0, 3'b000, 1'b1);
    repeat (3) begin cyc(1'b1, 3'b010, 1'b0); exp_cnt++; end
    repeat (24) cyc(1'b1, 3'b000, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 3'b010, 1'b0);
      exp_cnt += (DECAY || j == 0) ? 1 : 0;
    end
    chk("b_healthy_sb", 32'(bus.set_broken_o), DECAY ? 32'd0 : 32'd2);
    cyc(1'b1, 3'b010, 1'b0);
    exp_cnt += DECAY ? 1 : 0;
    chk("b_fourth_sb", 32'(bus.set_broken_o), 32'd2);
    chk("b_count2", 32'(bus.err_count_o), 32'(exp_cnt));

    // Two replicas disagree at once
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b1, 3'b110, 1'b0);
    exp_cnt++;
    chk("c_detected", 32'(bus.err_detected_o), 32'd1);
    chk("c_corrected", 32'(bus.err_corrected_o), 32'd0);
    chk("c_fatal", 32'(bus.fatal_o), 32'd1);
    repeat (3) cyc(1'b0, 3'b000, 1'b0);
    chk("c_fatal_held", 32'(bus.fatal_o), 32'd1);
    chk("c_det_idle", 32'(bus.err_detected_o), 32'd0);
    cyc(1'b0, 3'b000, 1'b1);
    chk("c_fatal_clr", 32'(bus.fatal_o), 32'd0);

    // Replica 0 BROKEN, then replica 1 misbehaves
    repeat (4) begin cyc(1'b1, 3'b001, 1'b0); exp_cnt++; end
    ib = 3'b001;
    cyc(1'b0, 3'b000, 1'b0);
    chk("d_sb_confirmed", 32'(bus.set_broken_o), 32'd0);
    chk("d_fatal_before", 32'(bus.fatal_o), 32'd0);
    repeat (4) begin
      cyc(1'b1, 3'b010, 1'b0);
      exp_cnt++;
      chk("d_detected", 32'(bus.err_detected_o), 32'd1);
      chk("d_corrected", 32'(bus.err_corrected_o), 32'd0);
      chk("d_fatal", 32'(bus.fatal_o), 32'd1);
    end
    chk("d_no_second_req", 32'(bus.set_broken_o), 32'd0);
    chk("d_count", 32'(bus.err_count_o), 32'(exp_cnt));

    // Clear while replica 2 is requested, clear beats a same-cycle mismatch
    ib = 3'b000;
    cyc(1'b0, 3'b000, 1'b1);
    repeat (4) begin cyc(1'b1, 3'b100, 1'b0); exp_cnt++; end
    chk("e_sb_req", 32'(bus.set_broken_o), 32'd4);
    cyc(1'b1, 3'b010, 1'b0);
    exp_cnt++;
    chk("e_fatal", 32'(bus.fatal_o), 32'd1);
    cyc(1'b1, 3'b010, 1'b1);
    chk("e_clr_sb", 32'(bus.set_broken_o), 32'd0);
    chk("e_clr_fatal", 32'(bus.fatal_o), 32'd0);
    chk("e_clr_det", 32'(bus.err_detected_o), 32'd0);
    chk("e_clr_cnt", 32'(bus.err_count_o), 32'(exp_cnt));
    cyc(1'b1, 3'b100, 1'b0);
    exp_cnt++;
    repeat (2) begin cyc(1'b1, 3'b100, 1'b0); exp_cnt++; end
    chk("e_score3", 32'(bus.set_broken_o), 32'd0);
    cyc(1'b1, 3'b100, 1'b0);
    exp_cnt++;
    chk("e_score4", 32'(bus.set_broken_o), 32'd4);
    chk("e_count", 32'(bus.err_count_o), 32'(exp_cnt));

    // Asynchronous reset in the middle of a request
    #2 rst_n = 1'b0;
    #1;
    chk("f_async_sb", 32'(bus.set_broken_o), 32'd0);
    chk("f_async_cnt", 32'(bus.err_count_o), 32'd0);
    #4 rst_n = 1'b1;
    cyc(1'b0, 3'b000, 1'b0);
    chk("f_after_rst_sb", 32'(bus.set_broken_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
